ad9833_multi_ctrl: RTL and testbench

AD9833_MULTI_CTRL -- requirements
Module: ad9833_multi_ctrl

---
 rtl/ad9833_multi_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ad9833_multi_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9833_multi_ctrl.sv
// rtl/ad9833_multi_ctrl.sv - serial write sequencer for up to four AD9833 DDS devices on a shared SCLK/SDATA bus
// Define AD9833_PHASE_WRITE_EN to append a PHASE0 word to every sequence.
module ad9833_multi_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 25
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  input  logic [1:0]        i_ch,
  input  logic [27:0]       i_freq,
  input  logic [11:0]       i_phase,
  input  logic [1:0]        i_wave,
  output logic [NUM_CH-1:0] o_fsync,
  output logic              o_sclk,
  output logic              o_sdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

`ifdef AD9833_PHASE_WRITE_EN
  localparam int NUM_WORDS = 4;
`else
  localparam int NUM_WORDS = 3;
`endif
  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [1:0]       LAST_WORD = 2'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [27:0]      freq_q, freq_d;
  logic [1:0]       wave_q, wave_d;
  logic [1:0]       word_q, word_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [3:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       nxt_idx;
  logic [15:0]      next_word;
  logic             ch_ok;

`ifdef AD9833_PHASE_WRITE_EN
  logic [11:0]      phase_q, phase_d;
`else
  logic             unused_phase;
  assign unused_phase = ^i_phase;
`endif

  function automatic logic [15:0] ctrl_word(input logic [1:0] wave);
    case (wave)
      2'b01:   ctrl_word = 16'h2002;
      2'b10:   ctrl_word = 16'h2028;
      default: ctrl_word = 16'h2000;
    endcase
  endfunction

  assign ch_ok   = 32'(i_ch) < NUM_CH;
  assign nxt_idx = word_q + 2'd1;

  // Words after the first come from the latched request; word 0 is built from the live inputs at accept time.
  always_comb begin
    next_word = ctrl_word(wave_q);
    case (nxt_idx)
      2'd1:    next_word = {2'b01, freq_q[13:0]};
      2'd2:    next_word = {2'b01, freq_q[27:14]};
`ifdef AD9833_PHASE_WRITE_EN
      2'd3:    next_word = {4'hC, phase_q};
`endif
      default: next_word = ctrl_word(wave_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    freq_d  = freq_q;
    wave_d  = wave_q;
`ifdef AD9833_PHASE_WRITE_EN
    phase_d = phase_q;
`endif
    word_d  = word_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_go) begin
          ch_d    = i_ch;
          freq_d  = i_freq;
          wave_d  = i_wave;
`ifdef AD9833_PHASE_WRITE_EN
          phase_d = i_phase;
`endif
          word_d  = 2'd0;
          shreg_d = ctrl_word(i_wave);
          bit_d   = 4'd0;
          div_d   = '0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = LOAD;
          frame_d = ch_ok;
          err_d   = !ch_ok;
        end
      end
      LOAD, SHIFT: begin
        if (err_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (sclk_q) begin
              sclk_d = 1'b0;
            end else if (bit_q == 4'd15) begin
              // Word complete: FSYNC and SCLK rise together
              sclk_d  = 1'b1;
              frame_d = 1'b0;
              shreg_d = '0;
              if (word_q == LAST_WORD) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
              end else begin
                state_d = GAP;
              end
            end else begin
              sclk_d  = 1'b1;
              bit_d   = bit_q + 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          word_d  = nxt_idx;
          shreg_d = next_word;
          bit_d   = 4'd0;
          sclk_d  = 1'b1;
          frame_d = 1'b1;
          state_d = LOAD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      freq_q  <= '0;
      wave_q  <= '0;
`ifdef AD9833_PHASE_WRITE_EN
      phase_q <= '0;
`endif
      word_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b1;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      freq_q  <= freq_d;
      wave_q  <= wave_d;
`ifdef AD9833_PHASE_WRITE_EN
      phase_q <= phase_d;
`endif
      word_q  <= word_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ch_q is stable for the whole frame, so each FSYNC only toggles with frame_q
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      o_fsync[k] = !(frame_q && (32'(ch_q) == k));
    end
  end

  assign o_ack   = i_rst_n && (state_q == IDLE) && i_go;
  assign o_busy  = busy_q || o_ack;
  assign o_sclk  = sclk_q;
  assign o_sdata = frame_q && shreg_q[15];
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_ad9833_multi_ctrl.sv
// tb/tb_ad9833_multi_ctrl.sv - scoreboard bench for ad9833_multi_ctrl (NUM_CH=2, CLK_DIV=2)
// Honours AD9833_PHASE_WRITE_EN the same way as the design.
module tb_ad9833_multi_ctrl;
  localparam int NUM_CH  = 2;
  localparam int CLK_DIV = 2;
`ifdef AD9833_PHASE_WRITE_EN
  localparam int NUM_WORDS = 4;
`else
  localparam int NUM_WORDS = 3;
`endif
  localparam int WIN     = 32 * CLK_DIV;
  localparam int SEQ_LAT = NUM_WORDS * WIN + (NUM_WORDS - 1) * CLK_DIV + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic [1:0]        ch = 2'd0;
  logic [27:0]       freq = 28'd0;
  logic [11:0]       phase = 12'd0;
  logic [1:0]        wave = 2'd0;
  logic [NUM_CH-1:0] o_fsync;
  logic              o_sclk, o_sdata, o_ack, o_busy, o_done, o_err;

  ad9833_multi_ctrl #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_go    (go),
    .i_ch    (ch),
    .i_freq  (freq),
    .i_phase (phase),
    .i_wave  (wave),
    .o_fsync (o_fsync),
    .o_sclk  (o_sclk),
    .o_sdata (o_sdata),
    .o_ack   (o_ack),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: rebuilds each frame as the device would see it and scores it against exp_q
  int          done_cnt = 0, err_cnt = 0, frame_cnt = 0;
  int          idle_sdata_bad = 0, sdata_change_bad = 0, multi_low_bad = 0;
  logic        in_frame = 1'b0, in_gap = 1'b0;
  int          win_len, nbits, gap_cnt;
  logic [15:0] cap;
  logic [1:0]  fch;
  logic [1:0]  low;
  logic [17:0] e;
  logic        prev_sclk = 1'b1, prev_sdata = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 1'b0;
      in_gap     = 1'b0;
      prev_sclk  = 1'b1;
      prev_sdata = 1'b0;
    end else begin
      low = ~o_fsync;
      if (low != 2'b00) begin
        if ($countones(low) > 1) multi_low_bad++;
        if (!in_frame) begin
          in_frame = 1'b1;
          frame_cnt++;
          win_len = 0;
          nbits   = 0;
          cap     = 16'h0;
          fch     = (low == 2'b10) ? 2'd1 : 2'd0;
          chk("sclk_high_at_fsync_fall", o_sclk, 1);
          if (in_gap) chk("gap_len", gap_cnt, CLK_DIV);
          in_gap = 1'b0;
        end else begin
          if (o_sdata !== prev_sdata && !(prev_sclk == 1'b0 && o_sclk == 1'b1)) sdata_change_bad++;
          if (prev_sclk == 1'b1 && o_sclk == 1'b0) begin
            cap = {cap[14:0], o_sdata};
            nbits++;
          end
        end
        win_len++;
      end else begin
        if (o_sdata !== 1'b0) idle_sdata_bad++;
        if (in_frame) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: got ch%0d word 0x%04h expected no frame", fch, cap);
          end else begin
            e = exp_q.pop_front();
            chk("frame_word", cap, e[15:0]);
            chk("frame_ch", fch, e[17:16]);
          end
          chk("window_len", win_len, WIN);
          chk("bits_per_word", nbits, 16);
          chk("sclk_high_at_fsync_rise", o_sclk, 1);
          in_gap  = 1'b1;
          gap_cnt = 1;
        end else if (in_gap) begin
          gap_cnt++;
        end
      end
      if (o_done) begin
        done_cnt++;
        in_gap = 1'b0;
      end
      if (o_err) err_cnt++;
      prev_sclk  = o_sclk;
      prev_sdata = o_sdata;
    end
  end

  task automatic push_seq(input logic [1:0] c, input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    exp_q.push_back({c, w0});
    exp_q.push_back({c, w1});
    exp_q.push_back({c, w2});
    if (NUM_WORDS == 4) exp_q.push_back({c, w3});
  endtask

  task automatic issue(input logic [1:0] c, input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    @(posedge clk);
    #1;
    ch = c; freq = f; phase = p; wave = w; go = 1'b1;
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_ack) break;
    end
    chk("ack_seen", o_ack, 1);
    chk("busy_at_ack", o_busy, 1);
  endtask

  task automatic drop_go();
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Called at the ack negedge (or start_k negedges after it)
  task automatic wait_done(input int start_k);
    int k;
    for (k = start_k + 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == start_k + 1) chk("busy_mid_seq", o_busy, 1);
      if (o_done) break;
    end
    chk("done_latency", k, SEQ_LAT);
    chk("busy_clear_at_done", o_busy, 0);
    chk("no_ack_at_done", o_ack, 0);
  endtask

  task automatic run_seq(input logic [1:0] c, input logic [27:0] f, input logic [11:0] p, input logic [1:0] w,
                         input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
    int d0;
    d0 = done_cnt;
    push_seq(c, w0, w1, w2, w3);
    issue(c, f, p, w);
    wait_ack();
    drop_go();
    wait_done(0);
    repeat (5) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int d0, f0, e0;
    rst_n = 1'b0;
    go    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fsync", o_fsync, 2'b11);
    chk("rst_sclk", o_sclk, 1);
    chk("rst_sdata", o_sdata, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; go = 1'b0;
    repeat (3) @(negedge clk);

    // directed vectors: control, FREQ0 LSB, FREQ0 MSB, PHASE0
    run_seq(2'd0, 28'h000000F, 12'h123, 2'b00, 16'h2000, 16'h400F, 16'h4000, 16'hC123);
    // 0xABCDEF1: [13:0] = 0x1EF1, [27:14] = 0x2AF3
    run_seq(2'd1, 28'hABCDEF1, 12'h000, 2'b10, 16'h2028, 16'h5EF1, 16'h6AF3, 16'hC000);
    run_seq(2'd0, 28'hFFFFFFF, 12'hFFF, 2'b11, 16'h2000, 16'h7FFF, 16'h7FFF, 16'hCFFF);
    run_seq(2'd1, 28'h0004000, 12'h000, 2'b01, 16'h2002, 16'h4000, 16'h4001, 16'hC000);

    // out-of-range channels
    for (int c = 2; c < 4; c++) begin
      d0 = done_cnt; f0 = frame_cnt; e0 = err_cnt;
      issue(2'(c), 28'h1111111, 12'h111, 2'b01);
      wait_ack();
      chk("err_not_at_ack", o_err, 0);
      drop_go();
      @(negedge clk);
      chk("err_after_ack", o_err, 1);
      @(negedge clk);
      chk("err_single_cycle", o_err, 0);
      chk("err_busy_clear", o_busy, 0);
      repeat (100) @(negedge clk);
      chk("err_no_frames", frame_cnt - f0, 0);
      chk("err_no_done", done_cnt - d0, 0);
      chk("err_count", err_cnt - e0, 1);
    end

    // reset during bit 7 of the second word
    exp_q.push_back({2'd0, 16'h2028});
    d0 = done_cnt;
    issue(2'd0, 28'h1234567, 12'h456, 2'b10);
    wait_ack();
    drop_go();
    repeat (96) @(negedge clk);
    chk("pre_reset_fsync", o_fsync, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_fsync", o_fsync, 2'b11);
    chk("async_rst_sclk", o_sclk, 1);
    chk("async_rst_sdata", o_sdata, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_done", o_done, 0);
    chk("async_rst_err", o_err, 0);
    repeat (3) @(negedge clk);
    chk("first_word_scored", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    f0 = frame_cnt;
    repeat (20) @(negedge clk);
    chk("no_resume_frames", frame_cnt - f0, 0);
    chk("no_resume_busy", o_busy, 0);
    chk("reset_no_done", done_cnt - d0, 0);
    // 0x1234567: [13:0] = 0x0567, [27:14] = 0x048D
    run_seq(2'd0, 28'h1234567, 12'h456, 2'b10, 16'h2028, 16'h4567, 16'h448D, 16'hC456);

    // back-to-back with i_go held, inputs disturbed mid-transfer
    d0 = done_cnt;
    push_seq(2'd1, 16'h2002, 16'h4001, 16'h4000, 16'hC000);
    issue(2'd1, 28'h0000001, 12'h000, 2'b01);
    wait_ack();
    @(posedge clk);
    #1 go = 1'b0; ch = 2'd0; freq = 28'hFFFFFFF; wave = 2'b10; phase = 12'h777;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 go = 1'b1; ch = 2'd3;
    repeat (20) @(negedge clk);
    chk("go_ignored_while_busy", o_ack, 0);
    push_seq(2'd0, 16'h2028, 16'h4000, 16'h6000, 16'hCABC);
    @(posedge clk);
    #1 ch = 2'd0; freq = 28'h8000000; phase = 12'hABC; wave = 2'b10;
    wait_done(40);
    @(negedge clk);
    chk("b2b_ack_after_done", o_ack, 1);
    drop_go();
    wait_done(0);
    repeat (5) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 2);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("sdata_idle_zero", idle_sdata_bad, 0);
    chk("sdata_changes_on_sclk_rise", sdata_change_bad, 0);
    chk("single_fsync_low", multi_low_bad, 0);
    chk("total_err_pulses", err_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
